local_history_btb: RTL and testbench

- Parametrised two-level local branch predictor with an integrated branch target buffer; successor to the fixed 8-entry local predictor.
- Sits beside the fetch stage: a combinational lookup on the fetch PC returns taken/target in the same cycle.
- Decode-stage resolution trains a per-entry local history register, a shared pattern history table (PHT) of 2-bit saturating counters, and the stored target.
- Adds tag allocation, configurable depth/history/tag width, and saturating performance counters.

---
 rtl/bpb_pkg.sv | 24 ++
 rtl/local_history_pht.sv | 28 ++
 rtl/local_history_btb.sv | 89 ++++++++
 tb/tb_local_history_btb.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bpb_pkg.sv
// bpb_pkg: shared types and helpers for the local-history branch predictor.
package bpb_pkg;

    typedef logic [1:0] pht_ctr_t;

    localparam pht_ctr_t SNT = 2'd0;
    localparam pht_ctr_t WNT = 2'd1;
    localparam pht_ctr_t WT  = 2'd2;
    localparam pht_ctr_t ST  = 2'd3;

    function automatic pht_ctr_t sat_update(input pht_ctr_t c, input logic taken);
        return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction

    // Callers narrow the result to IDX / TAG_WIDTH bits with a size cast.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx);
        return (pc >> 2) & ((32'd1 << idx) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx, input int tw);
        return (pc >> (idx + 2)) & ((32'd1 << tw) - 32'd1);
    endfunction

endpackage

// File: rtl/local_history_pht.sv
// local_history_pht: shared table of 2-bit saturating counters indexed by local history.
module local_history_pht
    import bpb_pkg::*;
#(
    parameter int HIST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HIST_BITS-1:0] rd_idx,
    output pht_ctr_t             rd_ctr,
    input  logic                 wr_en,
    input  logic [HIST_BITS-1:0] wr_idx,
    input  logic                 wr_taken
);

    pht_ctr_t pht [2**HIST_BITS];

    assign rd_ctr = pht[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**HIST_BITS; i++) pht[i] <= WNT;
        end else if (wr_en) begin
            pht[wr_idx] <= sat_update(pht[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/local_history_btb.sv
// local_history_btb: two-level local predictor with tagged BTB and saturating perf counters.
module local_history_btb
    import bpb_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int TAG_WIDTH = 12,
    parameter int HIST_BITS = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [31:0]          pc_f,
    input  logic [31:0]          pc_d,
    input  logic                 is_branch_d,
    input  logic                 real_taken,
    input  logic [31:0]          real_addr,
    input  logic                 mistake_d,
    output logic                 prd_hit,
    output logic                 prd_taken,
    output logic [31:0]          prd_addr,
    output logic [CNT_WIDTH-1:0] cnt_branch,
    output logic [CNT_WIDTH-1:0] cnt_mispredict
);

    localparam int IDX = $clog2(ENTRIES);

    logic [ENTRIES-1:0]   valid;
    logic [TAG_WIDTH-1:0] tags    [ENTRIES];
    logic [HIST_BITS-1:0] hist    [ENTRIES];
    logic [31:0]          targets [ENTRIES];

    logic [IDX-1:0]       idx_f, idx_d;
    logic [TAG_WIDTH-1:0] tag_f, tag_d;
    logic                 hit_d, upd;
    logic [HIST_BITS:0]   hist_shift;
    pht_ctr_t             ctr_f;

    assign idx_f = IDX'(pc_index(pc_f, IDX));
    assign idx_d = IDX'(pc_index(pc_d, IDX));
    assign tag_f = TAG_WIDTH'(pc_tag(pc_f, IDX, TAG_WIDTH));
    assign tag_d = TAG_WIDTH'(pc_tag(pc_d, IDX, TAG_WIDTH));

    assign prd_hit   = valid[idx_f] && (tags[idx_f] == tag_f);
    assign prd_taken = prd_hit && ctr_f[1];
    assign prd_addr  = prd_taken ? targets[idx_f] : 32'd0;

    assign upd        = is_branch_d && !stall && !flush;
    assign hit_d      = valid[idx_d] && (tags[idx_d] == tag_d);
    assign hist_shift = {hist[idx_d], real_taken};

    // Only hits train the PHT; a fresh allocation has no meaningful history yet.
    local_history_pht #(.HIST_BITS(HIST_BITS)) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (hist[idx_f]),
        .rd_ctr   (ctr_f),
        .wr_en    (upd && hit_d),
        .wr_idx   (hist[idx_d]),
        .wr_taken (real_taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid          <= '0;
            cnt_branch     <= '0;
            cnt_mispredict <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                hist[i]    <= '0;
                targets[i] <= '0;
            end
        end else if (upd) begin
            if (hit_d) begin
                hist[idx_d] <= hist_shift[HIST_BITS-1:0];
                if (real_taken) targets[idx_d] <= real_addr;
            end else begin
                valid[idx_d]   <= 1'b1;
                tags[idx_d]    <= tag_d;
                hist[idx_d]    <= HIST_BITS'(real_taken);
                targets[idx_d] <= real_taken ? real_addr : 32'd0;
            end
            if (!(&cnt_branch)) cnt_branch <= cnt_branch + CNT_WIDTH'(1);
            if (mistake_d && !(&cnt_mispredict)) cnt_mispredict <= cnt_mispredict + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_local_history_btb.sv
// tb_local_history_btb: directed checks of lookup, training, allocation, gating and reset.
module tb_local_history_btb;

    logic        clk = 1'b0;
    logic        reset, stall, flush, is_branch_d, real_taken, mistake_d;
    logic [31:0] pc_f, pc_d, real_addr, prd_addr;
    logic        prd_hit, prd_taken;
    logic [3:0]  cnt_branch, cnt_mispredict;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    local_history_btb #(.ENTRIES(16), .TAG_WIDTH(12), .HIST_BITS(4), .CNT_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .pc_f           (pc_f),
        .pc_d           (pc_d),
        .is_branch_d    (is_branch_d),
        .real_taken     (real_taken),
        .real_addr      (real_addr),
        .mistake_d      (mistake_d),
        .prd_hit        (prd_hit),
        .prd_taken      (prd_taken),
        .prd_addr       (prd_addr),
        .cnt_branch     (cnt_branch),
        .cnt_mispredict (cnt_mispredict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_lookup(input string tag, input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] addr);
        pc_f = pc;
        #1;
        chk({tag, ".hit"}, 32'(prd_hit), 32'(hit));
        chk({tag, ".taken"}, 32'(prd_taken), 32'(tk));
        chk({tag, ".addr"}, prd_addr, addr);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".cnt_branch"}, 32'(cnt_branch), exp_br);
        chk({tag, ".cnt_mispredict"}, 32'(cnt_mispredict), exp_mp);
    endtask

    task automatic step(input logic [31:0] pc, input logic tk, input logic [31:0] addr,
                        input logic mis, input logic st, input logic fl, input logic br);
        pc_d = pc; real_taken = tk; real_addr = addr; mistake_d = mis;
        stall = st; flush = fl; is_branch_d = br;
        @(posedge clk);
        if (br && !st && !fl) begin
            exp_br = (exp_br == 15) ? 15 : exp_br + 1;
            if (mis) exp_mp = (exp_mp == 15) ? 15 : exp_mp + 1;
        end
        #1;
        is_branch_d = 1'b0; mistake_d = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; is_branch_d = 1'b0;
        real_taken = 1'b0; mistake_d = 1'b0; pc_f = 32'h40; pc_d = 32'h0; real_addr = 32'h0;
        #12;
        chk_lookup("reset", 32'h40, 1'b0, 1'b0, 32'h0);
        chk_cnt("reset");
        @(negedge clk) reset = 1'b1;

        // First update allocates; history 0001 points at an untrained counter.
        step(32'h40, 1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_lookup("alloc", 32'h40, 1'b1, 1'b0, 32'h0);
        chk_cnt("alloc");
        step(32'h40, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h40, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pht1_wt", 32'(dut.u_pht.pht[1]), 32'd2);
        chk("pht3_wt", 32'(dut.u_pht.pht[3]), 32'd2);
        chk_lookup("taken3", 32'h40, 1'b1, 1'b0, 32'h0);
        chk_cnt("taken3");
        step(32'h40, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(32'h40, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_lookup("taken5", 32'h40, 1'b1, 1'b1, 32'h1000);

        // Not-taken training: history walks 1110,1100,1000,0000 then sticks at 0000.
        step(32'h40, 1'b0, 32'hdead0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pht15_wnt", 32'(dut.u_pht.pht[15]), 32'd1);
        chk_lookup("nt1", 32'h40, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(32'h40, 1'b0, 32'hdead0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pht0_sat0", 32'(dut.u_pht.pht[0]), 32'd0);
        chk("target_kept", dut.targets[0], 32'h1000);
        chk_lookup("nt6", 32'h40, 1'b1, 1'b0, 32'h0);
        chk_cnt("nt6");
        step(32'h40, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pht0_up", 32'(dut.u_pht.pht[0]), 32'd1);
        chk_lookup("retarget", 32'h40, 1'b1, 1'b1, 32'h3000);

        // Same index, different tag: entry is replaced.
        step(32'h440, 1'b0, 32'h4000, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_lookup("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
        chk_lookup("alias_new", 32'h440, 1'b1, 1'b0, 32'h0);
        chk("alias_target", dut.targets[0], 32'h0);
        chk_cnt("alias");

        step(32'h40, 1'b1, 32'h7000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(32'h40, 1'b1, 32'h7000, 1'b1, 1'b0, 1'b1, 1'b1);
        step(32'h40, 1'b1, 32'h7000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_lookup("gated_new", 32'h440, 1'b1, 1'b0, 32'h0);
        chk_lookup("gated_old", 32'h40, 1'b0, 1'b0, 32'h0);
        chk("gated_pht0", 32'(dut.u_pht.pht[0]), 32'd1);
        chk_cnt("gated");

        for (int i = 0; i < 20; i++) step(32'h84, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sat_branch", 32'(cnt_branch), 32'hF);
        chk("sat_mispredict", 32'(cnt_mispredict), 32'hF);
        chk_cnt("sat");

        // Asynchronous reset lands while an update is pending on the bus.
        pc_d = 32'h440; real_taken = 1'b1; real_addr = 32'h5000; mistake_d = 1'b1; is_branch_d = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        exp_br = 0; exp_mp = 0;
        chk_lookup("async_rst", 32'h440, 1'b0, 1'b0, 32'h0);
        chk_cnt("async_rst");
        @(posedge clk);
        #1 is_branch_d = 1'b0; mistake_d = 1'b0;
        @(negedge clk) reset = 1'b1;
        chk_lookup("post_rst", 32'h440, 1'b0, 1'b0, 32'h0);
        chk("post_rst_pht0", 32'(dut.u_pht.pht[0]), 32'd1);
        chk("post_rst_pht15", 32'(dut.u_pht.pht[15]), 32'd1);
        chk("post_rst_target", dut.targets[0], 32'h0);
        chk_cnt("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
